// File: rtl/axi_lite_regfile_if.sv
`default_nettype none
// ============================================================================
// Interface : axi_lite_channel
// Brief     : Single AXI-Lite link (AW/W/B/AR/R) with master and slave views.
// Revision  : 1.0 - initial release
// ============================================================================
interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

    modport slave (
        input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regfile
// Brief    : AXI-Lite register bank with byte-strobe writes and hw load ports.
//            Define AXI_LITE_REGFILE_PROT_EN to reject unprivileged accesses.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regfile #(
    parameter int                    ADDR_WIDTH = 48,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    axi_lite_channel.slave                 bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse,
    input  logic [NUM_REGS-1:0]            hw_we,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_d
);
    localparam int         c_STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int         c_BYTE_SHIFT  = $clog2(c_STRB_WIDTH);
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    function automatic logic [ADDR_WIDTH-1:0] f_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return offset >> c_BYTE_SHIFT;
    endfunction

    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >= BASE_ADDR) && (f_index(addr) < ADDR_WIDTH'(NUM_REGS));
    endfunction

    logic                    r_aw_held;
    logic [ADDR_WIDTH-1:0]   r_aw_addr;
    logic                    r_aw_priv;
    logic                    r_w_held;
    logic [DATA_WIDTH-1:0]   r_w_data;
    logic [c_STRB_WIDTH-1:0] r_w_strb;
    logic                    r_b_valid;
    logic [1:0]              r_b_resp;
    logic                    r_r_valid;
    logic [DATA_WIDTH-1:0]   r_r_data;
    logic [1:0]              r_r_resp;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]     r_wr_pulse;

    logic                    w_aw_fire;
    logic                    w_w_fire;
    logic                    w_ar_fire;
    logic                    w_commit;
    logic                    w_aw_priv_in;
    logic                    w_wr_in_range;
    logic                    w_wr_apply;
    logic                    w_rd_in_range;
    logic                    w_rd_priv;
    logic [ADDR_WIDTH-1:0]   w_wr_idx;
    logic [ADDR_WIDTH-1:0]   w_rd_idx;
    logic [NUM_REGS-1:0]     w_wr_sel;
    logic [DATA_WIDTH-1:0]   w_wr_mask;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_unused_prot;

`ifdef AXI_LITE_REGFILE_PROT_EN
    assign w_aw_priv_in = bus.aw_prot[0];
    assign w_rd_priv    = bus.ar_prot[0];
`else
    assign w_aw_priv_in = 1'b1;
    assign w_rd_priv    = 1'b1;
`endif
    assign w_unused_prot = ^{bus.aw_prot, bus.ar_prot};

    assign bus.aw_ready = !r_aw_held && !r_b_valid;
    assign bus.w_ready  = !r_w_held && !r_b_valid;
    assign bus.ar_ready = !r_r_valid;
    assign bus.b_valid  = r_b_valid;
    assign bus.b_resp   = r_b_resp;
    assign bus.r_valid  = r_r_valid;
    assign bus.r_data   = r_r_data;
    assign bus.r_resp   = r_r_resp;
    assign wr_pulse     = r_wr_pulse;

    assign w_aw_fire     = bus.aw_valid && bus.aw_ready;
    assign w_w_fire      = bus.w_valid && bus.w_ready;
    assign w_ar_fire     = bus.ar_valid && bus.ar_ready;
    // Commit only from registered slots, so a write lands one edge after its last handshake.
    assign w_commit      = r_aw_held && r_w_held && !r_b_valid;
    assign w_wr_idx      = f_index(r_aw_addr);
    assign w_wr_in_range = f_in_range(r_aw_addr);
    assign w_wr_apply    = w_commit && w_wr_in_range && r_aw_priv;
    assign w_rd_idx      = f_index(bus.ar_addr);
    assign w_rd_in_range = f_in_range(bus.ar_addr);

    always_comb begin
        w_wr_sel  = '0;
        w_wr_mask = '0;
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_apply && (w_wr_idx == ADDR_WIDTH'(i))) w_wr_sel[i] = 1'b1;
            if (w_rd_idx == ADDR_WIDTH'(i)) w_rd_data = r_regs[i];
        end
        for (int k = 0; k < c_STRB_WIDTH; k++) begin
            w_wr_mask[k*8 +: 8] = {8{r_w_strb[k]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_held  <= 1'b0;
            r_aw_addr  <= '0;
            r_aw_priv  <= 1'b0;
            r_w_held   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_b_valid  <= 1'b0;
            r_b_resp   <= c_RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= bus.aw_addr;
                r_aw_priv <= w_aw_priv_in;
            end else if (w_commit) begin
                r_aw_held <= 1'b0;
            end
            if (w_w_fire) begin
                r_w_held <= 1'b1;
                r_w_data <= bus.w_data;
                r_w_strb <= bus.w_strb;
            end else if (w_commit) begin
                r_w_held <= 1'b0;
            end
            if (w_commit) begin
                r_b_valid <= 1'b1;
                r_b_resp  <= !w_wr_in_range ? c_RESP_DECERR :
                             !r_aw_priv     ? c_RESP_SLVERR : c_RESP_OKAY;
            end else if (r_b_valid && bus.b_ready) begin
                r_b_valid <= 1'b0;
            end
            r_wr_pulse <= w_wr_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
            r_r_resp  <= c_RESP_OKAY;
        end else if (w_ar_fire) begin
            r_r_valid <= 1'b1;
            r_r_data  <= (w_rd_in_range && w_rd_priv) ? w_rd_data : '0;
            r_r_resp  <= !w_rd_in_range ? c_RESP_DECERR :
                         !w_rd_priv     ? c_RESP_SLVERR : c_RESP_OKAY;
        end else if (r_r_valid && bus.r_ready) begin
            r_r_valid <= 1'b0;
        end
    end

    // Bus commit beats a same-edge hardware load of the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_sel[i]) begin
                    r_regs[i] <= (r_regs[i] & ~w_wr_mask) | (r_w_data & w_wr_mask);
                end else if (hw_we[i]) begin
                    r_regs[i] <= hw_d[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_regfile
// Brief    : Randomized bench for axi_lite_regfile against a transaction-level
//            register model; honours AXI_LITE_REGFILE_PROT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regfile;
    localparam int          AW   = 48;
    localparam int          DW   = 64;
    localparam int          NR   = 16;
    localparam logic [47:0] BASE = 48'h0000_0000_4000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]    wr_pulse;
    logic [NR-1:0]    hw_we = '0;
    logic [NR*DW-1:0] hw_d = '0;

    axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .reg_q(reg_q),
        .wr_pulse(wr_pulse), .hw_we(hw_we), .hw_d(hw_d)
    );

    always #5 clk = ~clk;

    // Transaction-level model of the register bank and the visible handshake state.
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_pulse;
    logic          m_b_valid, m_r_valid, m_aw_held, m_w_held;
    logic [1:0]    m_b_resp, m_r_resp;
    logic [DW-1:0] m_r_data;
    bit            checking_on = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [NR-1:0] last_pulse;
    logic [1:0]    last_bresp, last_rresp;
    logic [DW-1:0] last_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic summary_and_finish();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic timeout(input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL timeout %s: got no handshake, expected one within 60 cycles", what);
        summary_and_finish();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_pulse = '0; m_b_valid = 0; m_r_valid = 0; m_aw_held = 0; m_w_held = 0;
        m_b_resp = 2'b00; m_r_resp = 2'b00; m_r_data = '0;
    endtask

    function automatic bit f_in_range(input logic [47:0] a);
        return (a >= BASE) && (((a - BASE) >> 3) < 48'(NR));
    endfunction

    function automatic int f_idx(input logic [47:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    function automatic bit f_priv(input logic [2:0] p);
`ifdef AXI_LITE_REGFILE_PROT_EN
        return p[0];
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [1:0] f_resp(input logic [47:0] a, input logic [2:0] p);
        if (!f_in_range(a)) return 2'b11;
        if (!f_priv(p))     return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (checking_on) begin
                for (int i = 0; i < NR; i++)
                    check($sformatf("reg_q[%0d]", i), reg_q[i*DW +: DW], m_regs[i]);
                check("wr_pulse", 64'(wr_pulse), 64'(m_pulse));
                check("b_valid", 64'(bus.b_valid), 64'(m_b_valid));
                if (m_b_valid) check("b_resp", 64'(bus.b_resp), 64'(m_b_resp));
                check("r_valid", 64'(bus.r_valid), 64'(m_r_valid));
                if (m_r_valid) begin
                    check("r_data", bus.r_data, m_r_data);
                    check("r_resp", 64'(bus.r_resp), 64'(m_r_resp));
                end
                check("aw_ready", 64'(bus.aw_ready), 64'(!(m_aw_held || m_b_valid)));
                check("w_ready", 64'(bus.w_ready), 64'(!(m_w_held || m_b_valid)));
                check("ar_ready", 64'(bus.ar_ready), 64'(!m_r_valid));
            end
        end
    end

    task automatic do_write(input logic [47:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input logic [2:0] prot,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [NR-1:0] clash_we, input logic [NR*DW-1:0] clash_d);
        int            cyc, idx;
        bit            aw_done, w_done, aw_hs, w_hs, ok;
        logic [DW-1:0] nv;
        cyc = 0; aw_done = 0; w_done = 0;
        bus.aw_addr = addr; bus.aw_prot = prot; bus.w_data = data; bus.w_strb = strb;
        while (!(aw_done && w_done)) begin
            bus.aw_valid = !aw_done && (cyc >= aw_dly);
            bus.w_valid  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            aw_hs = bus.aw_valid && bus.aw_ready;
            w_hs  = bus.w_valid && bus.w_ready;
            @(posedge clk);
            if (aw_hs) begin aw_done = 1; m_aw_held = 1; end
            if (w_hs)  begin w_done = 1;  m_w_held = 1;  end
            #1;
            cyc++;
            if (cyc > 60) timeout("write address/data");
        end
        bus.aw_valid = 0; bus.w_valid = 0;
        hw_we = clash_we; hw_d = clash_d;
        @(posedge clk);
        ok  = f_in_range(addr) && f_priv(prot);
        idx = ok ? f_idx(addr) : 0;
        nv  = m_regs[idx];
        for (int k = 0; k < 8; k++) if (strb[k]) nv[k*8 +: 8] = data[k*8 +: 8];
        for (int i = 0; i < NR; i++) if (clash_we[i]) m_regs[i] = clash_d[i*DW +: DW];
        m_pulse = '0;
        if (ok) begin
            m_regs[idx]  = nv;
            m_pulse[idx] = 1'b1;
        end
        m_b_valid = 1; m_b_resp = f_resp(addr, prot); m_aw_held = 0; m_w_held = 0;
        #1;
        hw_we = '0;
        cyc = 0;
        forever begin
            bus.b_ready = (cyc >= b_dly);
            @(negedge clk);
            if (cyc == 0) begin last_pulse = wr_pulse; last_bresp = bus.b_resp; end
            @(posedge clk);
            m_pulse = '0;
            if (bus.b_ready) begin m_b_valid = 0; break; end
            #1;
            cyc++;
        end
        #1;
        bus.b_ready = 0;
    endtask

    task automatic do_read(input logic [47:0] addr, input logic [2:0] prot,
                           input int ar_dly, input int r_dly);
        int cyc;
        bit hs;
        repeat (ar_dly) begin @(posedge clk); #1; end
        bus.ar_addr = addr; bus.ar_prot = prot; bus.ar_valid = 1;
        cyc = 0;
        forever begin
            @(negedge clk);
            hs = bus.ar_valid && bus.ar_ready;
            @(posedge clk);
            if (hs) begin
                m_r_valid = 1;
                m_r_resp  = f_resp(addr, prot);
                m_r_data  = (m_r_resp == 2'b00) ? m_regs[f_idx(addr)] : '0;
                break;
            end
            #1;
            cyc++;
            if (cyc > 60) timeout("read address");
        end
        #1;
        bus.ar_valid = 0;
        cyc = 0;
        forever begin
            bus.r_ready = (cyc >= r_dly);
            @(negedge clk);
            if (cyc == 0) begin last_rdata = bus.r_data; last_rresp = bus.r_resp; end
            @(posedge clk);
            if (bus.r_ready) begin m_r_valid = 0; break; end
            #1;
            cyc++;
        end
        #1;
        bus.r_ready = 0;
    endtask

    task automatic do_hw(input logic [NR-1:0] we, input logic [NR*DW-1:0] d);
        hw_we = we; hw_d = d;
        @(posedge clk);
        for (int i = 0; i < NR; i++) if (we[i]) m_regs[i] = d[i*DW +: DW];
        #1;
        hw_we = '0;
    endtask

    function automatic logic [NR*DW-1:0] rand_d();
        logic [NR*DW-1:0] v;
        for (int k = 0; k < NR*DW/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [47:0] rand_addr();
        int r;
        r = $urandom_range(0, 21);
        if (r < 16) return BASE + 48'(r * 8) + 48'($urandom_range(0, 7));
        if (r < 20) return BASE + 48'((NR + r - 16) * 8) + 48'($urandom_range(0, 7));
        return BASE - 48'((r - 19) * 8);
    endfunction

    initial begin
        #1000000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got no end of test, expected completion before 1000000");
        summary_and_finish();
    end

    initial begin
        logic [NR-1:0]    clash;
        logic [NR*DW-1:0] d;
        bus.aw_valid = 0; bus.w_valid = 0; bus.ar_valid = 0; bus.b_ready = 0; bus.r_ready = 0;
        bus.aw_addr = '0; bus.aw_prot = '0; bus.w_data = '0; bus.w_strb = '0;
        bus.ar_addr = '0; bus.ar_prot = '0;
        model_reset();
        #2;
        rst = 1;
        checking_on = 1;
        @(negedge clk);
        check("reset_aw_ready", 64'(bus.aw_ready), 64'd1);
        check("reset_w_ready", 64'(bus.w_ready), 64'd1);
        check("reset_ar_ready", 64'(bus.ar_ready), 64'd1);
        check("reset_r_data", bus.r_data, 64'd0);
        check("reset_b_resp", 64'(bus.b_resp), 64'd0);
        check("reset_r_resp", 64'(bus.r_resp), 64'd0);
        check("reset_reg_q0", reg_q[DW-1:0], 64'd0);
        @(posedge clk);
        #1;
        rst = 0;

        do_write(BASE + 48'h08, 64'h1122334455667788, 8'hFF, 3'b001, 0, 0, 0, '0, '0);
        check("tp_full_write_reg1", reg_q[DW +: DW], 64'h1122334455667788);
        check("tp_full_write_pulse", 64'(last_pulse), 64'h0002);
        check("tp_full_write_resp", 64'(last_bresp), 64'd0);

        do_write(BASE + 48'h08, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 3'b001, 3, 0, 1, '0, '0);
        check("tp_strb_write_reg1", reg_q[DW +: DW], 64'h11223344AAAAAAAA);

        do_read(BASE + 48'h08, 3'b001, 0, 4);
        check("tp_read_reg1", last_rdata, 64'h11223344AAAAAAAA);
        check("tp_read_resp", 64'(last_rresp), 64'd0);

        do_write(BASE + 48'(NR * 8), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'b001, 0, 1, 2, '0, '0);
        check("tp_oor_write_resp", 64'(last_bresp), 64'd3);
        check("tp_oor_write_pulse", 64'(last_pulse), 64'd0);
        do_read(BASE + 48'(NR * 8), 3'b001, 0, 0);
        check("tp_oor_read_data", last_rdata, 64'd0);
        check("tp_oor_read_resp", 64'(last_rresp), 64'd3);
        do_read(BASE - 48'h08, 3'b001, 0, 1);
        check("tp_below_base_resp", 64'(last_rresp), 64'd3);

        d = '0;
        d[2*DW +: DW] = 64'h5;
        do_write(BASE + 48'h10, 64'h9, 8'hFF, 3'b001, 0, 0, 0, 16'h0004, d);
        check("tp_hw_clash_reg2", reg_q[2*DW +: DW], 64'h9);

`ifdef AXI_LITE_REGFILE_PROT_EN
        do_write(BASE, 64'hDEAD, 8'hFF, 3'b000, 0, 0, 0, '0, '0);
        check("tp_unpriv_write_resp", 64'(last_bresp), 64'd2);
        check("tp_unpriv_write_reg0", reg_q[DW-1:0], 64'd0);
        do_write(BASE, 64'hDEAD, 8'hFF, 3'b001, 0, 0, 0, '0, '0);
        check("tp_priv_write_resp", 64'(last_bresp), 64'd0);
        check("tp_priv_write_reg0", reg_q[DW-1:0], 64'hDEAD);
        do_read(BASE, 3'b000, 0, 0);
        check("tp_unpriv_read_resp", 64'(last_rresp), 64'd2);
        check("tp_unpriv_read_data", last_rdata, 64'd0);
`endif

        // Reset with an AW parked in its slot and a read response waiting.
        bus.aw_addr = BASE + 48'h08; bus.aw_prot = 3'b001; bus.aw_valid = 1;
        bus.ar_addr = BASE + 48'h08; bus.ar_prot = 3'b001; bus.ar_valid = 1;
        @(posedge clk);
        m_aw_held = 1; m_r_valid = 1; m_r_data = m_regs[1]; m_r_resp = 2'b00;
        #1;
        bus.aw_valid = 0; bus.ar_valid = 0;
        @(negedge clk);
        #1;
        rst = 1;
        model_reset();
        #1;
        check("async_reset_reg1", reg_q[DW +: DW], 64'd0);
        check("async_reset_r_valid", 64'(bus.r_valid), 64'd0);
        check("async_reset_aw_ready", 64'(bus.aw_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 0;

        for (int n = 0; n < 300; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 5) begin
                clash = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
                do_write(rand_addr(), {$urandom, $urandom}, 8'($urandom), 3'($urandom),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                         clash, rand_d());
            end else if (op < 8) begin
                do_read(rand_addr(), 3'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
            end else begin
                do_hw(NR'($urandom), rand_d());
            end
        end

        repeat (2) @(posedge clk);
        summary_and_finish();
    end
endmodule
`default_nettype wire
